store_pack_buffer: RTL
======================

Name: store_pack_buffer

Overview:
- Store-side counterpart of the immediate/load extenders. It narrows a 32-bit register value to a byte, halfword or word, aligns it into its byte lane and generates the byte enables.
- Accepted stores are queued in a small in-order FIFO and drained to the data-memory write port over a valid/ready handshake.
- Sits between the MEM-stage store logic and the data memory.
- Provides a word-address hit check so the pipeline can stall loads that would read stale memory.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, >=2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- st_valid  input  1  store request present.
- st_ready  output  1  block can accept a request this cycle.
- st_op  input  2  00 sw, 01 sh, 10 sb, 11 illegal.
- st_addr  input  32  byte address.
- st_data  input  32  register value; only the low 8/16/32 bits are used.
- st_err  output  1  one-cycle pulse: the previously accepted request was misaligned or illegal.
- mem_valid  output  1  head entry presented to memory.
- mem_ready  input  1  memory takes the head entry.
- mem_addr  output  32  word address, bits [1:0] always 0.
- mem_wdata  output  32  lane-aligned write data.
- mem_be  output  4  byte enables; bit i covers mem_wdata[8i+7:8i].
- chk_addr  input  32  byte address of a pending load.
- chk_hit  output  1  combinational: some valid entry has mem_addr equal to {chk_addr[31:2],2'b00}.
- count  output  PTR_W+1  number of valid entries.
- empty  output  1  count==0.

Behaviour:
- Reset (reset_n low, asynchronous): FIFO cleared and pointers zeroed.
  - Reset values: count=0, empty=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, st_err=0, chk_hit=0.
  - Asserting reset mid-drain discards all queued entries. No partial write is ever presented after reset.
- Accept rule:
  - st_ready = (count!=DEPTH), independent of st_valid and mem_ready.
  - A request is accepted when st_valid && st_ready at a rising edge.
  - When full, the request must be held; a simultaneous drain frees the slot for the next cycle only.
- Packing (combinational, done at accept):
  - sb:
    - wdata = {4{st_data[7:0]}}
    - be = 4'b0001 << st_addr[1:0]
    - never misaligned.
  - sh:
    - Requires st_addr[0]==0.
    - wdata = {2{st_data[15:0]}}
    - be = st_addr[1] ? 4'b1100 : 4'b0011
  - sw:
    - Requires st_addr[1:0]==2'b00.
    - wdata = st_data
    - be = 4'b1111
  - The entry stores {st_addr[31:2],2'b00}, wdata and be.
- Error path:
  - Misaligned sh/sw or st_op==11 is still accepted (handshake completes) but not enqueued.
  - st_err is asserted for exactly the cycle after the accept. It is a registered pulse.
  - count does not change for an errored request.
- Queue and drain:
  - Circular buffer, write pointer wp, read pointer rp, PTR_W bits, wrapping modulo DEPTH.
  - count is tracked separately and distinguishes full from empty.
  - mem_valid = !empty. mem_addr, mem_wdata and mem_be show the head entry.
  - The head entry is held stable while mem_valid && !mem_ready.
  - A drain occurs when mem_valid && mem_ready.
- Latency: an accepted store can be seen on mem_valid no earlier than the next cycle. There is no bypass from st_* to mem_*.
- Simultaneous enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
  - When count==1, the newly enqueued entry becomes head on the following cycle.
- Ordering: strictly in order, no merging and no reordering.
- chk_hit:
  - Compares all valid entries, including the head.
  - Does not include a request being accepted in the same cycle.
  - Is 0 when empty.
- While mem_valid==0, the mem_addr/mem_wdata/mem_be values do not matter.

Decomposition:
- Shared header (backtick-defines, alongside the existing EXTOp codes): st_sw 2'b00, st_sh 2'b01, st_sb 2'b10.
- Sub-module store_pack: purely combinational.
  - Inputs: st_op, st_addr[1:0], st_data.
  - Outputs: wdata, be, misalign.
- The FIFO, pointers, error pulse and hit compare stay in store_pack_buffer.

Test Plan:
- Reset, then sb addr 0x1003 data 0xAABBCCDD -> next cycle mem_valid=1, mem_addr=0x1000, mem_wdata=0xDDDDDDDD, mem_be=4'b1000.
- sh addr 0x2002 data 0x00001234, then sw addr 0x2004 data 0xCAFEF00D, with mem_ready=1:
  - first write: be=1100, wdata=0x12341234
  - second write: be=1111, addr 0x2004.
- With mem_ready=0, issue 5 sb stores:
  - the 4th accept makes count=4 and st_ready=0
  - the 5th is held until one mem_ready pulse, then accepted.
  - mem_* stays constant while stalled.
- sw addr 0x3002 -> handshake completes, st_err=1 for one cycle, count stays 0, mem_valid stays 0.
- Queue sb 0x4001, then chk_addr=0x4003 -> chk_hit=1; chk_addr=0x4004 -> chk_hit=0; after the drain, chk_hit=0.
- Three entries queued, reset_n pulsed low mid-cycle -> count=0, mem_valid=0 immediately (asynchronous). No stale entry appears after release.

Source files
------------

// File: rtl/store_pack_buffer_pkg.sv
// Shared store-op encodings and the queued entry layout for the store pack buffer.
package store_pack_buffer_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_ILL = 2'b11
  } st_op_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_entry_t;

endpackage

// File: rtl/store_pack_buffer_pack.sv
// Narrows a register value to byte/half/word, replicates it across lanes and
// produces the matching byte enables plus an alignment/illegal-op flag.
module store_pack
  import store_pack_buffer_pkg::*;
(
  input  logic [1:0]  st_op_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        misalign_o
);

  st_op_e op;
  assign op = st_op_e'(st_op_i);

  always_comb begin
    wdata_o    = '0;
    be_o       = '0;
    misalign_o = 1'b0;
    case (op)
      ST_SW: begin
        wdata_o    = st_data_i;
        be_o       = 4'b1111;
        misalign_o = (st_addr_i != 2'b00);
      end
      ST_SH: begin
        wdata_o    = {2{st_data_i[15:0]}};
        be_o       = st_addr_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = st_addr_i[0];
      end
      ST_SB: begin
        wdata_o = {4{st_data_i[7:0]}};
        be_o    = 4'b0001 << st_addr_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_pack_buffer.sv
// In-order store queue between MEM-stage store logic and data memory, with a
// registered error pulse for bad stores and a word-address hit check for loads.
module store_pack_buffer
  import store_pack_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [1:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_err,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [31:0]      chk_addr,
  output logic             chk_hit,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  st_entry_t        fifo_q [DEPTH];
  st_entry_t        head;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_q, err_d;
  logic [31:0]      packWdata;
  logic [3:0]       packBe;
  logic             packMisalign;
  logic             accept, push, pop;
  logic [PTR_W-1:0] offs;

  store_pack u_pack (
    .st_op_i    (st_op),
    .st_addr_i  (st_addr[1:0]),
    .st_data_i  (st_data),
    .wdata_o    (packWdata),
    .be_o       (packBe),
    .misalign_o (packMisalign)
  );

  assign st_ready = (count_q != FULL);
  assign accept   = st_valid && st_ready;
  assign push     = accept && !packMisalign;
  assign empty    = (count_q == '0);
  assign pop      = !empty && mem_ready;
  assign count    = count_q;
  assign st_err   = err_q;

  always_comb begin
    wrPtr_d = wrPtr_q + PTR_W'(push);
    rdPtr_d = rdPtr_q + PTR_W'(pop);
    err_d   = accept && packMisalign;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wrPtr_q] <= '{addr: {st_addr[31:2], 2'b00}, wdata: packWdata, be: packBe};
    end
  end

  assign head      = fifo_q[rdPtr_q];
  assign mem_valid = !empty;
  assign mem_addr  = empty ? '0 : head.addr;
  assign mem_wdata = empty ? '0 : head.wdata;
  assign mem_be    = empty ? '0 : head.be;

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    chk_hit = 1'b0;
    offs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rdPtr_q;
      if (({1'b0, offs} < count_q) &&
          (((fifo_q[i].addr ^ chk_addr) & 32'hFFFF_FFFC) == 32'h0)) begin
        chk_hit = 1'b1;
      end
    end
  end

endmodule
